// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared types and helpers for the ALU issue controller
package alu_issue_ctrl_pkg;

  typedef enum logic [4:0] {
    CMD_AND = 5'b00000,
    CMD_EOR = 5'b00001,
    CMD_SUB = 5'b00010,
    CMD_RSB = 5'b00011,
    CMD_ADD = 5'b00100,
    CMD_ADC = 5'b00101,
    CMD_SBC = 5'b00110,
    CMD_RSC = 5'b00111,
    CMD_TST = 5'b01000,
    CMD_TEQ = 5'b01001,
    CMD_CMP = 5'b01010,
    CMD_CMN = 5'b01011,
    CMD_ORR = 5'b01100,
    CMD_MOV = 5'b01101,
    CMD_BIC = 5'b01110,
    CMD_MVN = 5'b01111,
    CMD_MUL = 5'b10000
  } alu_cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } ctrl_state_e;

  // TST/TEQ/CMP/CMN occupy 01000..01011: always set flags, never write back
  function automatic logic is_compare(input logic [4:0] cmd);
    return cmd[4:2] == 3'b010;
  endfunction

  function automatic logic is_mul(input logic [4:0] cmd);
    return cmd == CMD_MUL;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// rtl/alu_issue_ctrl_cond_eval.sv - condition code evaluation against NZCV
module alu_issue_ctrl_cond_eval
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign n = nzcv_i[3];
  assign z = nzcv_i[2];
  assign c = nzcv_i[1];
  assign v = nzcv_i[0];

  // ARM condition table; NV never executes
  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serial issue of one op at a time onto the registered ALU
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT   = 1,
  parameter int MUL_EXTRA = 2
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cond,
  input  logic [4:0]  req_cmd,
  input  logic        req_set_flags,
  input  logic [3:0]  req_rd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic        req_shift_carry,
  input  logic        req_was_shifted,
  output logic [4:0]  alu_cmd,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic        alu_shift_carry,
  output logic        alu_was_shifted,
  output logic [3:0]  alu_flags,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_nzcv,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [3:0]  flags,
  output logic        retire
);

  localparam int CNT_MAX = ALU_LAT - 1 + MUL_EXTRA;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  ctrl_state_e state_q, state_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [31:0] src1_q, src1_d, src2_q, src2_d;
  logic        sc_q, sc_d, ws_q, ws_d;
  logic        setf_q, setf_d;
  logic [3:0]  rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]  flags_q, flags_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        retire_q, retire_d;
  logic        cond_pass;

  alu_issue_ctrl_cond_eval u_cond_eval (
    .cond_i (req_cond),
    .nzcv_i (flags_q),
    .pass_o (cond_pass)
  );

  // State and datapath registers; reset discards any op in flight
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_MOV;
      src1_q     <= '0;
      src2_q     <= '0;
      sc_q       <= 1'b0;
      ws_q       <= 1'b0;
      setf_q     <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      sc_q       <= sc_d;
      ws_q       <= ws_d;
      setf_q     <= setf_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
    end
  end

  // Next-state: condition-failed ops never leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid && cond_pass) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = is_compare(cmd_q) ? ST_IDLE : ST_WB;
      ST_WB:   if (wb_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch on accept, count ALU latency, commit flags/writeback
  always_comb begin
    cmd_d      = cmd_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    sc_d       = sc_q;
    ws_d       = ws_q;
    setf_d     = setf_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    retire_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (cond_pass) begin
            cmd_d  = req_cmd;
            src1_d = req_op1;
            src2_d = req_op2;
            sc_d   = req_shift_carry;
            ws_d   = req_was_shifted;
            setf_d = req_set_flags;
            rd_d   = req_rd;
          end else begin
            retire_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (is_mul(cmd_q)) cnt_d = CNT_W'(ALU_LAT - 1 + MUL_EXTRA);
        else               cnt_d = CNT_W'(ALU_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (setf_q || is_compare(cmd_q)) flags_d = alu_nzcv;
          if (is_compare(cmd_q)) begin
            retire_d = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = alu_result;
          end
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          retire_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign alu_cmd         = cmd_q;
  assign alu_src1        = src1_q;
  assign alu_src2        = src2_q;
  assign alu_shift_carry = sc_q;
  assign alu_was_shifted = ws_q;
  assign alu_flags       = flags_q;
  assign flags           = flags_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign retire          = retire_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  localparam int ALU_LAT   = 1;
  localparam int MUL_EXTRA = 2;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        req_valid, req_ready;
  logic [3:0]  req_cond;
  logic [4:0]  req_cmd;
  logic        req_set_flags;
  logic [3:0]  req_rd;
  logic [31:0] req_op1, req_op2;
  logic        req_shift_carry, req_was_shifted;
  logic [4:0]  alu_cmd;
  logic [31:0] alu_src1, alu_src2;
  logic        alu_shift_carry, alu_was_shifted;
  logic [3:0]  alu_flags;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_nzcv = '0;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags;
  logic        retire;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  m_flags;
  logic [4:0]  m_cmd;
  logic [31:0] m_s1, m_s2;
  logic        m_sc, m_ws;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .MUL_EXTRA(MUL_EXTRA)) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond), .req_cmd(req_cmd),
    .req_set_flags(req_set_flags), .req_rd(req_rd), .req_op1(req_op1), .req_op2(req_op2),
    .req_shift_carry(req_shift_carry), .req_was_shifted(req_was_shifted),
    .alu_cmd(alu_cmd), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_shift_carry(alu_shift_carry), .alu_was_shifted(alu_was_shifted), .alu_flags(alu_flags),
    .alu_result(alu_result), .alu_nzcv(alu_nzcv),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flags(flags), .retire(retire)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {C, V, sum} of x + y + cin
  function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic cin);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    return {s[32], (x[31] == y[31]) && (s[31] != x[31]), s[31:0]};
  endfunction

  // Behavioural ALU: returns {NZCV, result}
  function automatic logic [35:0] alu_f(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] fl, input logic sc, input logic ws);
    logic [31:0] r;
    logic        c, v;
    logic [33:0] t;
    logic        arith;
    c = ws ? sc : fl[1];
    v = fl[0];
    arith = 1'b0;
    t = '0;
    r = '0;
    case (cmd)
      5'd0, 5'd8:   r = a & b;
      5'd1, 5'd9:   r = a ^ b;
      5'd2, 5'd10:  begin t = add3(a, ~b, 1'b1); arith = 1'b1; end
      5'd3:         begin t = add3(b, ~a, 1'b1); arith = 1'b1; end
      5'd4, 5'd11:  begin t = add3(a, b, 1'b0); arith = 1'b1; end
      5'd5:         begin t = add3(a, b, fl[1]); arith = 1'b1; end
      5'd6:         begin t = add3(a, ~b, fl[1]); arith = 1'b1; end
      5'd7:         begin t = add3(b, ~a, fl[1]); arith = 1'b1; end
      5'd12:        r = a | b;
      5'd13:        r = b;
      5'd14:        r = a & ~b;
      5'd15:        r = ~b;
      default:      begin r = a * b; c = fl[1]; end
    endcase
    if (arith) begin
      r = t[31:0];
      c = t[33];
      v = t[32];
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Condition codes come in complementary pairs; the low bit inverts the base test
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] fl);
    logic n, z, c, v, base;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    if (cond == 4'd14) return 1'b1;
    if (cond == 4'd15) return 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ cond[0];
  endfunction

  // External registered ALU
  always @(posedge clk) begin
    {alu_nzcv, alu_result} <= alu_f(alu_cmd, alu_src1, alu_src2, alu_flags, alu_shift_carry, alu_was_shifted);
  end

  task automatic model_reset();
    m_flags = 4'd0; m_cmd = 5'b01101; m_s1 = '0; m_s2 = '0; m_sc = 1'b0; m_ws = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] cond, input logic [4:0] cmd, input logic s, input logic [3:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic sc, input logic ws,
                       input int d, input int rst_at);
    logic        pass, cmpop;
    logic [35:0] r;
    int          mulx, first_wb, ret_cyc, n, hold;
    pass  = cond_ok(cond, m_flags);
    cmpop = (cmd >= 5'd8) && (cmd <= 5'd11);
    mulx  = (cmd == 5'd16) ? MUL_EXTRA : 0;
    r     = alu_f(cmd, a, b, m_flags, sc, ws);
    @(posedge clk); #1;
    chk("idle_ready", req_ready, 1);
    chk("retire_low_idle", retire, 0);
    req_cond = cond; req_cmd = cmd; req_set_flags = s; req_rd = rd;
    req_op1 = a; req_op2 = b; req_shift_carry = sc; req_was_shifted = ws;
    req_valid = 1'b1; wb_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; first_wb = 0; ret_cyc = 0; hold = 0;
    while (n < 60) begin
      if (rst_at == n) begin
        RESET_N = 1'b0;
        @(posedge clk); #1;
        RESET_N = 1'b1;
        wb_ready = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_flags", flags, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_retire", retire, 0);
        chk("rst_alu_cmd", alu_cmd, 5'b01101);
        chk("rst_alu_src1", alu_src1, 0);
        model_reset();
        return;
      end
      if (retire) begin
        ret_cyc = n;
        break;
      end
      if (pass) chk("busy_not_ready", req_ready, 0);
      if (wb_valid) begin
        hold++;
        if (first_wb == 0) first_wb = n;
        chk("wb_rd", wb_rd, rd);
        chk("wb_data", wb_data, r[31:0]);
        wb_ready = (hold > d);
      end else begin
        wb_ready = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    wb_ready = 1'b0;
    chk("retire_seen", ret_cyc != 0, 1);
    chk("wb_idle_after", wb_valid, 0);
    if (!pass) begin
      chk("fail_latency", ret_cyc, 1);
      chk("fail_no_wb", first_wb, 0);
    end else begin
      m_cmd = cmd; m_s1 = a; m_s2 = b; m_sc = sc; m_ws = ws;
      if (s || cmpop) m_flags = r[35:32];
      if (cmpop) begin
        chk("cmp_latency", ret_cyc, 2 + ALU_LAT + mulx);
        chk("cmp_no_wb", first_wb, 0);
      end else begin
        chk("wb_latency", first_wb, 2 + ALU_LAT + mulx);
        chk("wb_retire", ret_cyc, first_wb + d + 1);
      end
    end
    chk("alu_cmd", alu_cmd, m_cmd);
    chk("alu_src1", alu_src1, m_s1);
    chk("alu_src2", alu_src2, m_s2);
    chk("alu_shift", {alu_shift_carry, alu_was_shifted}, {m_sc, m_ws});
    chk("flags", flags, m_flags);
    chk("alu_flags", alu_flags, m_flags);
  endtask

  initial begin
    req_valid = 0; req_cond = 0; req_cmd = 0; req_set_flags = 0; req_rd = 0;
    req_op1 = 0; req_op2 = 0; req_shift_carry = 0; req_was_shifted = 0; wb_ready = 0;
    RESET_N = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    RESET_N = 1'b1;
    chk("reset_ready", req_ready, 1);
    chk("reset_flags", flags, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_retire", retire, 0);
    chk("reset_alu_cmd", alu_cmd, 5'b01101);
    chk("reset_alu_src", {alu_src1, alu_src2} != 64'd0, 0);
    chk("reset_wb", {wb_rd, wb_data} != 36'd0, 0);

    // ADDS overflow into sign
    do_op(4'd14, 5'd4, 1, 4'd1, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0);
    chk("adds_flags", flags, 4'b1001);
    // CMP equal, then ADDEQ without S
    do_op(4'd14, 5'd10, 0, 4'd0, 32'd5, 32'd5, 0, 0, 0, 0);
    chk("cmp_flags", flags, 4'b0110);
    do_op(4'd0, 5'd4, 0, 4'd2, 32'd3, 32'd4, 0, 0, 0, 0);
    chk("addeq_flags", flags, 4'b0110);
    // SUBNE with Z set, NV
    do_op(4'd1, 5'd2, 1, 4'd3, 32'd9, 32'd1, 0, 0, 0, 0);
    do_op(4'd15, 5'd4, 1, 4'd3, 32'd9, 32'd1, 1, 1, 0, 0);
    // MUL latency
    do_op(4'd14, 5'd16, 0, 4'd4, 32'd3, 32'hFFFF_FFFF, 0, 0, 0, 0);
    // writeback stall
    do_op(4'd14, 5'd13, 0, 4'd5, 32'd0, 32'hCAFE_F00D, 0, 0, 5, 0);
    // reset in WAIT and in WB
    do_op(4'd14, 5'd16, 1, 4'd6, 32'd7, 32'd9, 0, 0, 0, 2);
    do_op(4'd14, 5'd4, 1, 4'd7, 32'd1, 32'd2, 0, 0, 10, 4);
    do_op(4'd14, 5'd4, 1, 4'd8, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    chk("post_reset_flags", flags, 4'b0110);

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = ($urandom_range(0, 1) == 1) ? 4'd14 : 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
      do_op(c, 5'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
